// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit path.
//   state_t       - framer FSM states
//   IDLE_LEVEL    - line level while idle and during the stop bit
//   START_LEVEL   - line level during the start bit
//   clks_per_bit  - clk cycles per bit for a given clock frequency and baud rate
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Integer divide; any fractional remainder is simply dropped.
  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter for the UART framer.
//   clk      in  system clock
//   rst      in  asynchronous active-high reset
//   restart  in  hold the count at 0 (the next counted cycle is cycle 0 of a bit)
//   bit_pre  out high during the second-to-last cycle of a bit period
//   bit_end  out high during the last cycle of a bit period (count = CLKS_PER_BIT-1)
// Both outputs are registered: they are decoded from the next count value.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_pre,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PRE_CNT  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;

  // Next count: wrap at the end of each bit so a new bit always starts at 0.
  always_comb begin
    cnt_next_s = cnt_r + CNT_W'(1);
    if (restart || (cnt_r == LAST_CNT)) begin
      cnt_next_s = '0;
    end else begin
      cnt_next_s = cnt_r + CNT_W'(1);
    end
  end

  // Count register and registered end-of-bit decodes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= '0;
      bit_pre <= 1'b0;
      bit_end <= 1'b0;
    end else begin
      cnt_r   <= cnt_next_s;
      bit_pre <= (cnt_next_s == PRE_CNT);
      bit_end <= (cnt_next_s == LAST_CNT);
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: serialises strobed bytes onto a UART line
// (start bit, DATA_BITS data bits LSB first, optional parity, stop bit),
// with a one-entry holding register for a strobe arriving mid-frame.
//   clk       in  system clock
//   rst       in  asynchronous active-high reset
//   tx_en     in  one-cycle load strobe
//   tx_data   in  byte to send, sampled when tx_en = 1
//   tx        out serial line, idles high
//   busy      out frame in flight or holding register full
//   tx_done   out one-cycle pulse on the last cycle of each stop bit
//   overflow  out sticky: a strobe was dropped because the hold register was full
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD),
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_en,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done,
  output logic                 overflow
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  state_t               state_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [IDX_W-1:0]     bit_idx_r;
  logic [DATA_BITS-1:0] hold_r;
  logic                 hold_valid_r;
  logic                 parity_r;
  logic                 bit_pre_s;
  logic                 bit_end_s;
  logic                 frame_end_s;

  function automatic logic frame_parity(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  // Counter is held at 0 in IDLE; elsewhere it wraps on its own at each bit end.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(state_r == IDLE),
    .bit_pre(bit_pre_s),
    .bit_end(bit_end_s)
  );

  assign frame_end_s = (state_r == STOP) && bit_end_s;

  // Framer FSM: every output is set for the state being entered, so tx is a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      shift_r      <= '0;
      bit_idx_r    <= '0;
      hold_r       <= '0;
      hold_valid_r <= 1'b0;
      parity_r     <= 1'b0;
      tx           <= IDLE_LEVEL;
      busy         <= 1'b0;
      tx_done      <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      tx_done <= (state_r == STOP) && bit_pre_s;

      // Mid-frame strobe: fill the hold register, or drop it if already full.
      // The frame-end cycle is handled in STOP, where the hold register drains.
      if (tx_en && (state_r != IDLE) && !frame_end_s) begin
        if (hold_valid_r) begin
          overflow <= 1'b1;
        end else begin
          hold_r       <= tx_data;
          hold_valid_r <= 1'b1;
        end
      end

      case (state_r)
        IDLE: begin
          if (tx_en) begin
            state_r  <= START;
            shift_r  <= tx_data;
            parity_r <= frame_parity(tx_data);
            tx       <= START_LEVEL;
            busy     <= 1'b1;
          end else begin
            tx   <= IDLE_LEVEL;
            busy <= 1'b0;
          end
        end
        START: begin
          if (bit_end_s) begin
            state_r   <= DATA;
            bit_idx_r <= '0;
            tx        <= shift_r[0];
          end
        end
        DATA: begin
          if (bit_end_s) begin
            if (bit_idx_r == LAST_IDX) begin
              if (PARITY_EN != 0) begin
                state_r <= PARITY;
                tx      <= parity_r;
              end else begin
                state_r <= STOP;
                tx      <= IDLE_LEVEL;
              end
            end else begin
              shift_r   <= shift_r >> 1;
              tx        <= shift_r[1];
              bit_idx_r <= bit_idx_r + IDX_W'(1);
            end
          end
        end
        PARITY: begin
          if (bit_end_s) begin
            state_r <= STOP;
            tx      <= IDLE_LEVEL;
          end
        end
        STOP: begin
          if (bit_end_s) begin
            if (hold_valid_r) begin
              // Held byte goes first; a same-cycle strobe refills the hold register.
              state_r  <= START;
              shift_r  <= hold_r;
              parity_r <= frame_parity(hold_r);
              tx       <= START_LEVEL;
              if (tx_en) begin
                hold_r <= tx_data;
              end else begin
                hold_valid_r <= 1'b0;
              end
            end else if (tx_en) begin
              state_r  <= START;
              shift_r  <= tx_data;
              parity_r <= frame_parity(tx_data);
              tx       <= START_LEVEL;
            end else begin
              state_r <= IDLE;
              tx      <= IDLE_LEVEL;
              busy    <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          tx      <= IDLE_LEVEL;
          busy    <= hold_valid_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: directed self-checking bench for uart_tx_framer.
// CLK_FREQ = 400, BAUD = 100, so each bit lasts 4 clk cycles. Each scenario
// fills per-cycle stimulus/expectation tables, then replays them one cycle at
// a time: inputs driven 1 time unit after posedge, outputs sampled at negedge.
// Cycle c strobed => frame occupies cycles c+1 .. c+40.
module tb_uart_tx_framer;

  localparam int NCYC = 130;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_en = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx, busy, tx_done, overflow;

  logic       tx_en_p = 1'b0;
  logic [7:0] tx_data_p = 8'h00;
  logic       tx_pe, busy_pe, done_pe, ovf_pe;
  logic       tx_po, busy_po, done_po, ovf_po;

  int n_checks = 0;
  int n_fail   = 0;

  logic       en_s     [NCYC];
  logic [7:0] dat_s    [NCYC];
  logic       exp_tx   [NCYC];
  logic       exp_busy [NCYC];
  logic       exp_done [NCYC];
  logic       exp_ovf  [NCYC];

  always #5 clk = ~clk;

  uart_tx_framer #(.CLK_FREQ(400), .BAUD(100), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .tx_data(tx_data),
    .tx(tx), .busy(busy), .tx_done(tx_done), .overflow(overflow)
  );

  uart_tx_framer #(.CLK_FREQ(400), .BAUD(100), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_pe (
    .clk(clk), .rst(rst), .tx_en(tx_en_p), .tx_data(tx_data_p),
    .tx(tx_pe), .busy(busy_pe), .tx_done(done_pe), .overflow(ovf_pe)
  );

  uart_tx_framer #(.CLK_FREQ(400), .BAUD(100), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) dut_po (
    .clk(clk), .rst(rst), .tx_en(tx_en_p), .tx_data(tx_data_p),
    .tx(tx_po), .busy(busy_po), .tx_done(done_po), .overflow(ovf_po)
  );

  task automatic chk(input string tag, input int cyc, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_sched();
    for (int c = 0; c < NCYC; c++) begin
      en_s[c]     = 1'b0;
      dat_s[c]    = 8'h00;
      exp_tx[c]   = 1'b1;
      exp_busy[c] = 1'b0;
      exp_done[c] = 1'b0;
      exp_ovf[c]  = 1'b0;
    end
  endtask

  task automatic strobe_at(input int c, input logic [7:0] d);
    en_s[c]  = 1'b1;
    dat_s[c] = d;
  endtask

  // bits[0] is the start bit, bits[9] the stop bit.
  task automatic put_frame(input int c0, input logic [9:0] bits);
    for (int b = 0; b < 10; b++) begin
      for (int j = 0; j < 4; j++) begin
        exp_tx[c0 + 4*b + j]   = bits[b];
        exp_busy[c0 + 4*b + j] = 1'b1;
      end
    end
    exp_done[c0 + 39] = 1'b1;
  endtask

  task automatic ovf_from(input int c0);
    for (int c = c0; c < NCYC; c++) exp_ovf[c] = 1'b1;
  endtask

  task automatic run(input int n, input string tag);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      tx_en   = en_s[c];
      tx_data = dat_s[c];
      @(negedge clk);
      chk({tag, "_tx"},   c, tx,       exp_tx[c]);
      chk({tag, "_busy"}, c, busy,     exp_busy[c]);
      chk({tag, "_done"}, c, tx_done,  exp_done[c]);
      chk({tag, "_ovf"},  c, overflow, exp_ovf[c]);
    end
    tx_en = 1'b0;
  endtask

  initial begin
    logic [10:0] fe;
    logic [10:0] fo;

    // Reset state
    #12;
    chk("rst_tx", 0, tx, 1'b1);
    chk("rst_busy", 0, busy, 1'b0);
    chk("rst_done", 0, tx_done, 1'b0);
    chk("rst_ovf", 0, overflow, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Single byte A5: line 0,1,0,1,0,0,1,0,1,1
    clear_sched();
    strobe_at(0, 8'hA5);
    put_frame(1, 10'b1101001010);
    run(45, "single");

    // Back-to-back: second byte held, sent with no idle gap
    clear_sched();
    strobe_at(0, 8'h3C);
    strobe_at(10, 8'hC3);
    put_frame(1, 10'b1001111000);
    put_frame(41, 10'b1110000110);
    run(85, "b2b");

    // Strobe on the tx_done cycle with the hold register empty
    clear_sched();
    strobe_at(0, 8'h0F);
    strobe_at(40, 8'h55);
    put_frame(1, 10'b1000011110);
    put_frame(41, 10'b1010101010);
    run(85, "done_strobe");

    // Strobe on the tx_done cycle with the hold register full: no overflow
    clear_sched();
    strobe_at(0, 8'h11);
    strobe_at(5, 8'h22);
    strobe_at(40, 8'h33);
    put_frame(1, 10'b1000100010);
    put_frame(41, 10'b1001000100);
    put_frame(81, 10'b1001100110);
    run(125, "done_hold");

    // Overflow: 01 sent, 02 held then sent, 03 dropped; flag sticky
    clear_sched();
    strobe_at(0, 8'h01);
    strobe_at(1, 8'h02);
    strobe_at(2, 8'h03);
    put_frame(1, 10'b1000000010);
    put_frame(41, 10'b1000000100);
    ovf_from(3);
    run(90, "overflow");

    // Reset mid-frame during data bit 3 of FF (overflow still set until rst)
    clear_sched();
    strobe_at(0, 8'hFF);
    put_frame(1, 10'b1111111110);
    ovf_from(0);
    run(19, "pre_rst");
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_tx", 0, tx, 1'b1);
    chk("async_rst_busy", 0, busy, 1'b0);
    chk("async_rst_done", 0, tx_done, 1'b0);
    chk("async_rst_ovf", 0, overflow, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("held_rst_tx", 0, tx, 1'b1);
    rst = 1'b0;

    // Clean frame after reset
    clear_sched();
    strobe_at(0, 8'h00);
    put_frame(1, 10'b1000000000);
    run(45, "post_rst");

    // Parity: 07 has three ones -> even parity bit 1, odd parity bit 0; 44-cycle frame
    fe = 11'b11000001110;
    fo = 11'b10000001110;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      tx_en_p   = (c == 0);
      tx_data_p = 8'h07;
      @(negedge clk);
      if (c >= 1 && c <= 44) begin
        chk("par_even_tx", c, tx_pe, fe[(c - 1) / 4]);
        chk("par_odd_tx",  c, tx_po, fo[(c - 1) / 4]);
      end else begin
        chk("par_even_idle", c, tx_pe, 1'b1);
        chk("par_odd_idle",  c, tx_po, 1'b1);
      end
      chk("par_even_done", c, done_pe, (c == 44));
      chk("par_odd_done",  c, done_po, (c == 44));
      chk("par_even_busy", c, busy_pe, (c >= 1 && c <= 44));
      chk("par_odd_busy",  c, busy_po, (c >= 1 && c <= 44));
    end
    tx_en_p = 1'b0;
    chk("par_even_ovf", 0, ovf_pe, 1'b0);
    chk("par_odd_ovf",  0, ovf_po, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
